drawbridge_seq: RTL and testbench
=================================

DRAWBRIDGE_SEQ -- requirements
Module: drawbridge_seq

Interface
REQ-001 SHALL have parameter LANES, default 2, number of car lanes (legal 1..4).
REQ-002 SHALL have parameter CNT_W, default 6, car-counter width (legal >= 3).
REQ-003 SHALL have parameter ALERT_CYC, default 8, warning cycles before the barrier closes (legal >= 1).
REQ-004 SHALL have parameter MOVE_CYC, default 16, cycles for full bridge travel (legal 2..255).
REQ-005 SHALL have port i_clk, input, 1, clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset, input, 1, reset: synchronous, active-low; clock i_clk.
REQ-007 SHALL have port i_carIn, input, LANES, per-lane one-cycle car-entered pulse.
REQ-008 SHALL have port i_carOut, input, LANES, per-lane one-cycle car-left pulse.
REQ-009 SHALL have port i_boatClose, input, 1, boat approaching (level).
REQ-010 SHALL have port i_boatHere, input, 1, boat at bridge (level).
REQ-011 SHALL have port o_carBarrier, output, 1, barrier closed.
REQ-012 SHALL have port o_alert, output, 1, warning lights on.
REQ-013 SHALL have port o_bridgeUp, output, 1, bridge fully raised.
REQ-014 SHALL have port o_bridgeMoving, output, 1, bridge raising or lowering.
REQ-015 SHALL have port o_carCount, output, CNT_W, cars on deck.
REQ-016 SHALL have port o_state, output, 3, current FSM state code.
REQ-017 SHALL have port o_fault, output, 1, sticky fault flag.

Function
REQ-018 SHALL update count each cycle by popcount(i_carIn) - popcount(i_carOut); simultaneous in/out on any lanes net out in the same cycle.
REQ-019 SHALL saturate count at 0 and 2^CNT_W-1; a clamped update SHALL set o_fault.
REQ-020 SHALL set o_fault on any i_carIn bit while state is RAISING, UP or LOWERING; o_fault SHALL clear only on reset.
REQ-021 SHALL define boat = i_boatClose | i_boatHere.
REQ-022 SHALL implement states IDLE=0, ALERT=1, CLEAR=2, RAISING=3, UP=4, LOWERING=5; codes 6-7 SHALL go to IDLE next cycle.
REQ-023 IDLE: boat -> ALERT, timer <= ALERT_CYC-1.
REQ-024 ALERT: !boat -> IDLE; else timer==0 -> CLEAR; else decrement timer.
REQ-025 CLEAR: !boat -> IDLE; else count==0 (registered value) -> RAISING, timer <= MOVE_CYC-1.
REQ-026 RAISING: timer==0 -> UP; else decrement; boat loss does not abort raising.
REQ-027 UP: !boat -> LOWERING, timer <= MOVE_CYC-1.
REQ-028 LOWERING: boat -> RAISING with timer <= MOVE_CYC-1-timer (reversal preserves position); else timer==0 -> IDLE; else decrement.
REQ-029 Outputs SHALL be Moore, decoded from the registered state: o_alert=1 in all states except IDLE; o_carBarrier=1 in CLEAR, RAISING, UP, LOWERING; o_bridgeMoving=1 in RAISING, LOWERING; o_bridgeUp=1 only in UP.
REQ-030 o_carCount and o_state SHALL reflect the registered values, one cycle after the causing input.
REQ-031 With boat held and count 0, ALERT SHALL last exactly ALERT_CYC cycles, CLEAR 1 cycle, and RAISING MOVE_CYC cycles.

Reset
REQ-032 While i_reset=0 at a rising edge: state IDLE, count 0, timer 0, o_fault 0; all outputs 0 on the following cycle.
REQ-033 Reset mid-RAISING, UP or LOWERING SHALL take effect immediately, with no travel completion.
REQ-034 Pulses on i_carIn or i_carOut during reset SHALL be ignored.

Verification
REQ-035 Defaults; 3 carIn pulses on lane 0, then i_carIn=2'b11 and i_carOut=2'b01 in one cycle -> o_carCount=4, o_fault=0.
REQ-036 Count 0, i_boatClose=1 held -> o_alert rises 1 cycle later; o_carBarrier rises after 8 ALERT cycles; o_bridgeMoving high for 16 cycles; then o_bridgeUp=1.
REQ-037 Count 2 in CLEAR -> state held at 2; two carOut pulses -> RAISING on the cycle after count reads 0.
REQ-038 In LOWERING with timer=10, assert i_boatHere -> RAISING with timer=5; o_bridgeUp rises 6 cycles later.
REQ-039 Count 0 with a carOut pulse -> count stays 0 and o_fault=1; carIn pulse in UP -> o_fault=1; fault persists until i_reset=0.
REQ-040 Drop boat during ALERT at timer=3 -> IDLE next cycle; o_alert=0 and o_carBarrier never asserted.

Source files
------------

// File: rtl/drawbridge_seq.sv
// -----------------------------------------------------------------------------
// drawbridge_seq
// Sequencer for a lifting road bridge. It counts the cars on the deck, warns
// road traffic when a boat approaches, closes the barrier, raises the bridge
// once the deck is empty, and lowers it again after the boat has gone.
//
// Parameters
//   LANES     : number of car lanes (1..4)
//   CNT_W     : car-counter width (>= 3)
//   ALERT_CYC : warning cycles before the barrier closes (>= 1)
//   MOVE_CYC  : cycles for one full bridge travel (2..255)
//
// Ports
//   i_clk          : clock, rising edge
//   i_reset        : synchronous reset, active low
//   i_carIn        : per-lane one-cycle pulse, car entered the deck
//   i_carOut       : per-lane one-cycle pulse, car left the deck
//   i_boatClose    : boat approaching (level)
//   i_boatHere     : boat at the bridge (level)
//   o_carBarrier   : road barrier closed
//   o_alert        : warning lights on
//   o_bridgeUp     : bridge fully raised
//   o_bridgeMoving : bridge raising or lowering
//   o_carCount     : cars currently on the deck
//   o_state        : current FSM state code
//   o_fault        : sticky fault (counter clamp or car entering a moving/up deck)
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | road open, no boat
//   ALERT    | warning lights on, counting down before the barrier closes
//   CLEAR    | barrier closed, waiting for the deck to empty
//   RAISING  | bridge travelling up
//   UP       | bridge fully raised, waiting for the boat to pass
//   LOWERING | bridge travelling down
// -----------------------------------------------------------------------------
module drawbridge_seq #(
    parameter int LANES     = 2,
    parameter int CNT_W     = 6,
    parameter int ALERT_CYC = 8,
    parameter int MOVE_CYC  = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [LANES-1:0] i_carIn,
    input  logic [LANES-1:0] i_carOut,
    input  logic             i_boatClose,
    input  logic             i_boatHere,
    output logic             o_carBarrier,
    output logic             o_alert,
    output logic             o_bridgeUp,
    output logic             o_bridgeMoving,
    output logic [CNT_W-1:0] o_carCount,
    output logic [2:0]       o_state,
    output logic             o_fault
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ALERT    = 3'd1,
        CLEAR    = 3'd2,
        RAISING  = 3'd3,
        UP       = 3'd4,
        LOWERING = 3'd5
    } state_t;

    // One shared down-counter serves both the alert and the travel phases.
    localparam int TMAX  = (ALERT_CYC > MOVE_CYC) ? ALERT_CYC : MOVE_CYC;
    localparam int TMR_W = $clog2(TMAX);
    localparam int SUM_W = CNT_W + 2;

    localparam logic [TMR_W-1:0] ALERT_LOAD = TMR_W'(ALERT_CYC - 1);
    localparam logic [TMR_W-1:0] MOVE_LOAD  = TMR_W'(MOVE_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [SUM_W-1:0] CNT_MAX    = {2'b00, {CNT_W{1'b1}}};

    state_t                    state;
    state_t                    stateNext;
    logic [TMR_W-1:0]          timer;
    logic [TMR_W-1:0]          timerNext;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          countNext;
    logic                      clampHit;
    logic [2:0]                numIn;
    logic [2:0]                numOut;
    logic signed [SUM_W-1:0]   sum;
    logic                      boat;
    logic                      travelling;

    assign boat       = i_boatClose | i_boatHere;
    assign travelling = (state == RAISING) || (state == UP) || (state == LOWERING);

    // Car counter: net in/out per cycle, saturating at both ends.
    always_comb begin
        numIn  = '0;
        numOut = '0;
        for (int i = 0; i < LANES; i++) begin
            numIn  = numIn  + 3'(i_carIn[i]);
            numOut = numOut + 3'(i_carOut[i]);
        end
        sum       = $signed({2'b00, count}) + $signed(SUM_W'(numIn)) - $signed(SUM_W'(numOut));
        clampHit  = 1'b0;
        countNext = sum[CNT_W-1:0];
        if (sum < 0) begin
            countNext = '0;
            clampHit  = 1'b1;
        end else if (sum > $signed(CNT_MAX)) begin
            countNext = '1;
            clampHit  = 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        timerNext = timer;
        case (state)
            IDLE: begin
                if (boat) begin
                    stateNext = ALERT;
                    timerNext = ALERT_LOAD;
                end
            end
            ALERT: begin
                if (!boat) begin
                    stateNext = IDLE;
                end else if (timer == '0) begin
                    stateNext = CLEAR;
                end else begin
                    timerNext = timer - TMR_ONE;
                end
            end
            CLEAR: begin
                // Uses the registered count, so the deck must read empty
                // for a full cycle before the bridge starts to move.
                if (!boat) begin
                    stateNext = IDLE;
                end else if (count == '0) begin
                    stateNext = RAISING;
                    timerNext = MOVE_LOAD;
                end
            end
            RAISING: begin
                if (timer == '0) begin
                    stateNext = UP;
                end else begin
                    timerNext = timer - TMR_ONE;
                end
            end
            UP: begin
                if (!boat) begin
                    stateNext = LOWERING;
                    timerNext = MOVE_LOAD;
                end
            end
            LOWERING: begin
                // Reversal: remaining lower time mirrors into remaining raise time.
                if (boat) begin
                    stateNext = RAISING;
                    timerNext = MOVE_LOAD - timer;
                end else if (timer == '0) begin
                    stateNext = IDLE;
                end else begin
                    timerNext = timer - TMR_ONE;
                end
            end
            default: begin
                stateNext = IDLE;
                timerNext = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with o_state.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state          <= IDLE;
            timer          <= '0;
            count          <= '0;
            o_fault        <= 1'b0;
            o_alert        <= 1'b0;
            o_carBarrier   <= 1'b0;
            o_bridgeMoving <= 1'b0;
            o_bridgeUp     <= 1'b0;
        end else begin
            state          <= stateNext;
            timer          <= timerNext;
            count          <= countNext;
            o_fault        <= o_fault | clampHit | (travelling & (|i_carIn));
            o_alert        <= (stateNext != IDLE);
            o_carBarrier   <= (stateNext == CLEAR) || (stateNext == RAISING) ||
                              (stateNext == UP)    || (stateNext == LOWERING);
            o_bridgeMoving <= (stateNext == RAISING) || (stateNext == LOWERING);
            o_bridgeUp     <= (stateNext == UP);
        end
    end

    assign o_carCount = count;
    assign o_state    = state;

endmodule

// File: tb/tb_drawbridge_seq.sv
module tb_drawbridge_seq;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [1:0] i_carIn;
    logic [1:0] i_carOut;
    logic       i_boatClose;
    logic       i_boatHere;
    logic       o_carBarrier;
    logic       o_alert;
    logic       o_bridgeUp;
    logic       o_bridgeMoving;
    logic [5:0] o_carCount;
    logic [2:0] o_state;
    logic       o_fault;

    int errors = 0;
    int checks = 0;

    drawbridge_seq #(
        .LANES(2), .CNT_W(6), .ALERT_CYC(8), .MOVE_CYC(16)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_carIn       (i_carIn),
        .i_carOut      (i_carOut),
        .i_boatClose   (i_boatClose),
        .i_boatHere    (i_boatHere),
        .o_carBarrier  (o_carBarrier),
        .o_alert       (o_alert),
        .o_bridgeUp    (o_bridgeUp),
        .o_bridgeMoving(o_bridgeMoving),
        .o_carCount    (o_carCount),
        .o_state       (o_state),
        .o_fault       (o_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkIdleOutputs(input string tag);
        chk({tag, "_state"},   32'(o_state), 0);
        chk({tag, "_alert"},   32'(o_alert), 0);
        chk({tag, "_barrier"}, 32'(o_carBarrier), 0);
        chk({tag, "_moving"},  32'(o_bridgeMoving), 0);
        chk({tag, "_up"},      32'(o_bridgeUp), 0);
    endtask

    initial begin
        i_reset     = 1'b0;
        i_carIn     = '0;
        i_carOut    = '0;
        i_boatClose = 1'b0;
        i_boatHere  = 1'b0;

        // Reset state, pulses during reset ignored
        tick(2);
        chkIdleOutputs("rst");
        chk("rst_count", 32'(o_carCount), 0);
        chk("rst_fault", 32'(o_fault), 0);
        i_carIn = 2'b11;
        tick();
        i_carIn = 2'b00;
        chk("rst_carin_ignored", 32'(o_carCount), 0);
        i_reset = 1'b1;
        tick();
        chk("post_rst_state", 32'(o_state), 0);

        // Car counting: 3 in on lane 0, then 2 in / 1 out in one cycle
        for (int i = 0; i < 3; i++) begin
            i_carIn = 2'b01;
            tick();
            i_carIn = 2'b00;
            if (i == 0) chk("count_first_pulse", 32'(o_carCount), 1);
            tick();
        end
        chk("count_three", 32'(o_carCount), 3);
        i_carIn  = 2'b11;
        i_carOut = 2'b01;
        tick();
        i_carIn  = 2'b00;
        i_carOut = 2'b00;
        chk("count_net", 32'(o_carCount), 4);
        chk("count_net_fault", 32'(o_fault), 0);
        i_carOut = 2'b11;
        tick(2);
        i_carOut = 2'b00;
        chk("count_drain", 32'(o_carCount), 0);
        chk("count_drain_fault", 32'(o_fault), 0);

        // Boat dropped during ALERT at timer=3
        i_boatClose = 1'b1;
        tick();
        chk("abort_alert_state", 32'(o_state), 1);
        chk("abort_alert_on", 32'(o_alert), 1);
        for (int i = 0; i < 4; i++) begin
            chk("abort_barrier_low", 32'(o_carBarrier), 0);
            tick();
        end
        chk("abort_still_alert", 32'(o_state), 1);
        i_boatClose = 1'b0;
        tick();
        chkIdleOutputs("abort_idle");

        // Full raise sequence
        i_boatClose = 1'b1;
        tick();
        chk("raise_alert_state", 32'(o_state), 1);
        chk("raise_alert_on", 32'(o_alert), 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("raise_alert_hold", 32'(o_state), 1);
            chk("raise_alert_barrier", 32'(o_carBarrier), 0);
        end
        tick();
        chk("raise_clear_state", 32'(o_state), 2);
        chk("raise_clear_barrier", 32'(o_carBarrier), 1);
        chk("raise_clear_moving", 32'(o_bridgeMoving), 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("raise_moving", 32'(o_bridgeMoving), 1);
            chk("raise_state", 32'(o_state), 3);
        end
        tick();
        chk("up_state", 32'(o_state), 4);
        chk("up_flag", 32'(o_bridgeUp), 1);
        chk("up_moving", 32'(o_bridgeMoving), 0);

        // Lowering, reversal at timer=10
        i_boatClose = 1'b0;
        tick();
        chk("lower_state", 32'(o_state), 5);
        chk("lower_moving", 32'(o_bridgeMoving), 1);
        chk("lower_up", 32'(o_bridgeUp), 0);
        tick(5);
        chk("lower_t10_state", 32'(o_state), 5);
        i_boatHere = 1'b1;
        tick();
        chk("reverse_state", 32'(o_state), 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reverse_raising", 32'(o_state), 3);
            chk("reverse_not_up", 32'(o_bridgeUp), 0);
        end
        tick();
        chk("reverse_up_state", 32'(o_state), 4);
        chk("reverse_up_flag", 32'(o_bridgeUp), 1);

        // Car entering while bridge is up
        i_carIn = 2'b01;
        tick();
        i_carIn = 2'b00;
        chk("fault_up_set", 32'(o_fault), 1);
        chk("fault_up_count", 32'(o_carCount), 1);
        tick(3);
        chk("fault_up_sticky", 32'(o_fault), 1);

        // Reset while UP: immediate
        i_reset = 1'b0;
        tick();
        chkIdleOutputs("rst_up");
        chk("rst_up_fault", 32'(o_fault), 0);
        chk("rst_up_count", 32'(o_carCount), 0);
        i_boatHere = 1'b0;
        i_reset    = 1'b1;
        tick();

        // CLEAR waits for an empty deck
        i_carIn = 2'b11;
        tick();
        i_carIn = 2'b00;
        chk("clear_count2", 32'(o_carCount), 2);
        i_boatClose = 1'b1;
        tick();
        chk("clear_alert", 32'(o_state), 1);
        tick(8);
        chk("clear_entered", 32'(o_state), 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clear_held", 32'(o_state), 2);
        end
        i_carOut = 2'b01;
        tick();
        chk("clear_count1", 32'(o_carCount), 1);
        chk("clear_held_c1", 32'(o_state), 2);
        tick();
        i_carOut = 2'b00;
        chk("clear_count0", 32'(o_carCount), 0);
        chk("clear_held_c0", 32'(o_state), 2);
        tick();
        chk("clear_to_raising", 32'(o_state), 3);
        chk("clear_to_raising_moving", 32'(o_bridgeMoving), 1);

        // Reset mid-RAISING
        i_reset = 1'b0;
        tick();
        chkIdleOutputs("rst_raise");
        i_boatClose = 1'b0;
        i_reset     = 1'b1;
        tick();

        // Underflow clamp
        i_carOut = 2'b01;
        tick();
        i_carOut = 2'b00;
        chk("under_count", 32'(o_carCount), 0);
        chk("under_fault", 32'(o_fault), 1);
        tick(2);
        chk("under_sticky", 32'(o_fault), 1);
        i_reset = 1'b0;
        tick();
        chk("under_rst_clear", 32'(o_fault), 0);
        i_reset = 1'b1;
        tick();

        // Overflow clamp at 63
        i_carIn = 2'b11;
        tick(31);
        chk("over_count62", 32'(o_carCount), 62);
        chk("over_nofault", 32'(o_fault), 0);
        tick();
        chk("over_count63", 32'(o_carCount), 63);
        chk("over_fault", 32'(o_fault), 1);
        tick();
        i_carIn = 2'b00;
        chk("over_hold63", 32'(o_carCount), 63);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
